// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
package regfile_write_arbiter_pkg;

    // Arbiter FSM states: free arbitration, or a burst owned by one requester.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } arb_state_e;

    // Requester indices as stored in the round-robin pointer.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Address width handled by the one-hot decode helper (banks up to 256 registers).
    localparam int ONEHOT_ADDR_W = 8;

    // One bit of the one-hot decode: register idx is selected when addr equals idx.
    function automatic logic onehot_bit(input logic [ONEHOT_ADDR_W-1:0] addr,
                                        input logic [ONEHOT_ADDR_W-1:0] idx);
        return (addr == idx);
    endfunction

endpackage

// File: rtl/regfile_load_decoder.sv
// Combinational LOAD strobe decoder: address plus enable to a one-hot vector,
// with register 0 optionally masked as a hard-wired zero register.
module regfile_load_decoder
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]   addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    // Decode each strobe; register 0 never loads when it is the zero register.
    always_comb begin
        onehot = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (en && onehot_bit(ONEHOT_ADDR_W'(addr), ONEHOT_ADDR_W'(i)) &&
                !((ZERO_REG != 32'sd0) && (i == 32'sd0))) begin
                onehot[i] = 1'b1;
            end else begin
                onehot[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the register bank, with optional locked
// bursts (bounded while the other side waits), registered LOAD/data outputs
// and a wrapping committed-write counter.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REGS  = 8,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int MAX_BURST = 4,
    parameter int ZERO_REG  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a_valid,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                a_lock,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    input  logic                b_lock,
    output logic                b_ready,
    output logic [NUM_REGS-1:0] load,
    output logic [DATA_W-1:0]   wdata,
    output logic [7:0]          wr_count
);

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    arb_state_e          state_r, state_s;
    logic                rr_ptr_r, rr_ptr_s;
    logic [3:0]          burst_r, burst_s, burst_inc_s;
    logic                grant_a_s, grant_b_s, hs_a_s, hs_b_s, wr_en_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [NUM_REGS-1:0] load_next_s, load_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [7:0]          wr_count_r;

    // Grant selection: the lock owner only, otherwise round-robin between valids.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (a_valid && b_valid) begin
                    if (rr_ptr_r == REQ_A) begin
                        grant_a_s = 1'b1;
                    end else begin
                        grant_b_s = 1'b1;
                    end
                end else begin
                    grant_a_s = a_valid;
                    grant_b_s = b_valid;
                end
            end
            ST_LOCK_A: grant_a_s = a_valid;
            ST_LOCK_B: grant_b_s = b_valid;
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // Readys are forced low while reset is held.
    assign a_ready = grant_a_s & rst_n;
    assign b_ready = grant_b_s & rst_n;
    assign hs_a_s  = a_valid & a_ready;
    assign hs_b_s  = b_valid & b_ready;
    assign wr_en_s = hs_a_s | hs_b_s;

    // Burst counter advance, saturating at the burst limit.
    always_comb begin
        if (burst_r >= MAX_BURST_C) begin
            burst_inc_s = MAX_BURST_C;
        end else begin
            burst_inc_s = burst_r + 4'd1;
        end
    end

    // Next-state logic: lock entry/exit, burst limit and round-robin pointer.
    always_comb begin
        state_s  = state_r;
        rr_ptr_s = rr_ptr_r;
        burst_s  = burst_r;
        case (state_r)
            ST_IDLE: begin
                if (hs_a_s) begin
                    if (a_lock && !((MAX_BURST_C == 4'd1) && b_valid)) begin
                        state_s = ST_LOCK_A;
                        burst_s = 4'd1;
                    end else begin
                        rr_ptr_s = REQ_B;
                    end
                end else if (hs_b_s) begin
                    if (b_lock && !((MAX_BURST_C == 4'd1) && a_valid)) begin
                        state_s = ST_LOCK_B;
                        burst_s = 4'd1;
                    end else begin
                        rr_ptr_s = REQ_A;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOCK_A: begin
                if (!hs_a_s || !a_lock || ((burst_inc_s == MAX_BURST_C) && b_valid)) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = REQ_B;
                    burst_s  = 4'd0;
                end else begin
                    burst_s = burst_inc_s;
                end
            end
            ST_LOCK_B: begin
                if (!hs_b_s || !b_lock || ((burst_inc_s == MAX_BURST_C) && a_valid)) begin
                    state_s  = ST_IDLE;
                    rr_ptr_s = REQ_A;
                    burst_s  = 4'd0;
                end else begin
                    burst_s = burst_inc_s;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                rr_ptr_s = REQ_A;
                burst_s  = 4'd0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= REQ_A;
            burst_r  <= 4'd0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            burst_r  <= burst_s;
        end
    end

    // Winning requester's address and data (the two handshakes are exclusive).
    assign sel_addr_s = hs_b_s ? b_addr : a_addr;
    assign sel_data_s = hs_b_s ? b_data : a_data;

    regfile_load_decoder #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_decoder (
        .addr   (sel_addr_s),
        .en     (wr_en_s),
        .onehot (load_next_s)
    );

    // Registered bank strobes, write data and committed-write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_r     <= {NUM_REGS{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            wr_count_r <= 8'd0;
        end else begin
            load_r <= load_next_s;
            if (wr_en_s) begin
                wdata_r <= sel_data_s;
            end else begin
                wdata_r <= wdata_r;
            end
            if (|load_next_s) begin
                wr_count_r <= wr_count_r + 8'd1;
            end else begin
                wr_count_r <= wr_count_r;
            end
        end
    end

    assign load     = load_r;
    assign wdata    = wdata_r;
    assign wr_count = wr_count_r;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus random
// traffic, compared against a behavioural owner/turn/streak model.
module tb_regfile_write_arbiter;

    localparam int NUM_REGS  = 8;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int MAX_BURST = 4;
    localparam int ZERO_REG  = 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                a_valid = 1'b0, b_valid = 1'b0;
    logic                a_lock = 1'b0, b_lock = 1'b0;
    logic [ADDR_W-1:0]   a_addr = '0, b_addr = '0;
    logic [DATA_W-1:0]   a_data = '0, b_data = '0;
    logic                a_ready, b_ready;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   wdata;
    logic [7:0]          wr_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: who owns the port, whose turn it is, burst length.
    int   owner;
    int   turn;
    int   streak;
    int   mv[2];
    int   ml[2];
    int   ma[2];
    int   md[2];
    logic [NUM_REGS-1:0] exp_load;
    logic [DATA_W-1:0]   exp_wdata;
    int   exp_count;
    int   winners[$];

    regfile_write_arbiter #(
        .NUM_REGS (NUM_REGS), .DATA_W (DATA_W), .ADDR_W (ADDR_W),
        .MAX_BURST(MAX_BURST), .ZERO_REG (ZERO_REG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_lock(a_lock), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_lock(b_lock), .b_ready(b_ready),
        .load(load), .wdata(wdata), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        owner = -1; turn = 0; streak = 0;
        exp_load = '0; exp_wdata = '0; exp_count = 0;
    endfunction

    // Who the spec says gets the port this cycle (-1 for nobody).
    function automatic int model_pick();
        if (owner >= 0) return (mv[owner] != 0) ? owner : -1;
        if (mv[0] != 0 && mv[1] != 0) return turn;
        if (mv[0] != 0) return 0;
        if (mv[1] != 0) return 1;
        return -1;
    endfunction

    function automatic void model_update(input int w);
        if (owner >= 0) begin
            if (w < 0) begin
                turn = 1 - owner; owner = -1; streak = 0;
            end else begin
                streak = (streak + 1 > MAX_BURST) ? MAX_BURST : streak + 1;
                if (ml[w] == 0 || (streak == MAX_BURST && mv[1-w] != 0)) begin
                    owner = -1; turn = 1 - w; streak = 0;
                end
            end
        end else if (w >= 0) begin
            if (ml[w] != 0) begin
                owner = w; streak = 1;
                if (streak >= MAX_BURST && mv[1-w] != 0) begin
                    owner = -1; turn = 1 - w; streak = 0;
                end
            end else begin
                turn = 1 - w;
            end
        end
        if (w >= 0) begin
            exp_wdata = DATA_W'(md[w]);
            if (ZERO_REG != 0 && ma[w] == 0) exp_load = '0;
            else exp_load = NUM_REGS'(1) << ma[w];
            if (exp_load != '0) exp_count = (exp_count + 1) % 256;
        end else begin
            exp_load = '0;
        end
    endfunction

    task automatic drive_cycle(input int va, input int la, input int aa, input int ad,
                               input int vb, input int lb, input int ab, input int bd);
        int w;
        @(negedge clk);
        a_valid = (va != 0); a_lock = (la != 0); a_addr = ADDR_W'(aa); a_data = DATA_W'(ad);
        b_valid = (vb != 0); b_lock = (lb != 0); b_addr = ADDR_W'(ab); b_data = DATA_W'(bd);
        mv[0] = va; ml[0] = la; ma[0] = aa; md[0] = ad;
        mv[1] = vb; ml[1] = lb; ma[1] = ab; md[1] = bd;
        #1;
        w = model_pick();
        chk("a_ready", 32'(a_ready), (w == 0) ? 32'd1 : 32'd0);
        chk("b_ready", 32'(b_ready), (w == 1) ? 32'd1 : 32'd0);
        winners.push_back(w);
        @(posedge clk);
        model_update(w);
        #1;
        chk("load", 32'(load), 32'(exp_load));
        chk("wdata", 32'(wdata), 32'(exp_wdata));
        chk("wr_count", 32'(wr_count), 32'(exp_count));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        chk("rst_count", 32'(wr_count), 32'd0);
    endtask

    initial begin
        string pattern;
        model_reset();
        do_reset();

        // Reset asserted mid-stream while load shows register 4.
        drive_cycle(1, 0, 4, 8'h3C, 0, 0, 0, 0);
        chk("pre_rst_load", 32'(load), 32'h10);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_load", 32'(load), 32'd0);
        chk("async_count", 32'(wr_count), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) drive_cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Single requester write.
        do_reset();
        drive_cycle(1, 0, 3, 8'hA5, 0, 0, 0, 0);
        chk("single_load", 32'(load), 32'h08);
        chk("single_wdata", 32'(wdata), 32'hA5);
        chk("single_count", 32'(wr_count), 32'd1);

        // Round robin, both valid, no lock: A B A B.
        do_reset();
        winners.delete();
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 2, 8'h11 + i, 1, 0, 5, 8'h66 + i);
        pattern = "";
        foreach (winners[i]) pattern = {pattern, (winners[i] == 0) ? "A" : (winners[i] == 1) ? "B" : "-"};
        chk("rr_seq", (pattern == "ABAB") ? 32'd1 : 32'd0, 32'd1);

        // Locked burst: A four times, then B, then A again.
        do_reset();
        winners.delete();
        for (int i = 0; i < 8; i++) drive_cycle(1, 1, 6, 8'h20 + i, 1, 0, 7, 8'h70 + i);
        pattern = "";
        foreach (winners[i]) pattern = {pattern, (winners[i] == 0) ? "A" : (winners[i] == 1) ? "B" : "-"};
        chk("burst_seq", (pattern == "AAAABAAA") ? 32'd1 : 32'd0, 32'd1);

        // Zero register write from B.
        do_reset();
        drive_cycle(1, 0, 1, 8'h01, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 1, 0, 0, 8'hFF);
        chk("zero_load", 32'(load), 32'd0);
        chk("zero_count", 32'(wr_count), 32'd1);

        // Counter wrap: 256 back-to-back writes to register 1.
        do_reset();
        for (int i = 0; i < 256; i++) drive_cycle(1, 0, 1, i, 0, 0, 0, 0);
        chk("wrap_count", 32'(wr_count), 32'd0);
        chk("wrap_load", 32'(load), 32'h02);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_cycle(($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 2) != 0) ? 1 : 0,
                        $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 255),
                        ($urandom_range(0, 3) != 0) ? 1 : 0, ($urandom_range(0, 2) != 0) ? 1 : 0,
                        $urandom_range(0, NUM_REGS - 1), $urandom_range(0, 255));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
